// File: rtl/at_req_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : at_req_sched_pkg
// Brief   : Shared widths, defaults and the update request record for the
//           and-tree request scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package at_req_sched_pkg;

    localparam int REQ_ID_WIDTH        = 4;
    localparam int AT_TREE_INDEX_WIDTH = 6;
    localparam int REQ_SIZE_TYPE_WIDTH = 2;
    localparam int AT_TREE_BIT_WIDTH   = 4;

    localparam int UPD_FIFO_DEPTH_DEF  = 4;
    localparam int STARVE_LIMIT_DEF    = 8;

    // Bit values are ordered {4k,2k,1k,512}.
    typedef struct packed {
        logic [AT_TREE_INDEX_WIDTH-1:0] row;
        logic [AT_TREE_INDEX_WIDTH-1:0] col;
        logic [AT_TREE_BIT_WIDTH-1:0]   bits;
    } upd_req_t;

    localparam int AT_UPD_REQ_WIDTH = $bits(upd_req_t);

    function automatic upd_req_t pack_upd_req(
        input logic [AT_TREE_INDEX_WIDTH-1:0] row,
        input logic [AT_TREE_INDEX_WIDTH-1:0] col,
        input logic [AT_TREE_BIT_WIDTH-1:0]   bits
    );
        upd_req_t req;
        req.row  = row;
        req.col  = col;
        req.bits = bits;
        return req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/at_upd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : at_upd_fifo
// Brief   : Synchronous FIFO for buffered and-tree bit updates; head, full and
//           empty derive straight from the storage and pointer registers.
// Revision: 1.0 - initial release
// ============================================================================
module at_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB separates full from empty when the indices coincide.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_head    = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/at_req_sched.sv
`default_nettype none
// ============================================================================
// Module  : at_req_sched
// Brief   : Issues fdt searches and or_tree bit updates to the and-tree ports,
//           holding back accesses to rows with a read-modify-write in flight.
// Revision: 1.0 - initial release
// ============================================================================
module at_req_sched
    import at_req_sched_pkg::*;
#(
    parameter int UPD_FIFO_DEPTH = UPD_FIFO_DEPTH_DEF,
    parameter int STARVE_LIMIT   = STARVE_LIMIT_DEF
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic                           alloc_valid_in,
    output logic                           alloc_ready_out,
    input  logic [REQ_ID_WIDTH-1:0]        alloc_id_in,
    input  logic [AT_TREE_INDEX_WIDTH-1:0] alloc_pos_in,
    input  logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_size_in,

    input  logic                           upd_valid_in,
    output logic                           upd_ready_out,
    input  logic [AT_TREE_INDEX_WIDTH-1:0] upd_row_in,
    input  logic [AT_TREE_INDEX_WIDTH-1:0] upd_col_in,
    input  logic [AT_TREE_BIT_WIDTH-1:0]   upd_bits_in,

    output logic                           at_alloc_valid,
    output logic [REQ_ID_WIDTH-1:0]        at_alloc_id,
    output logic [AT_TREE_INDEX_WIDTH-1:0] at_alloc_pos,
    output logic [REQ_SIZE_TYPE_WIDTH-1:0] at_alloc_size,

    output logic                           at_upd_en,
    output logic [AT_TREE_INDEX_WIDTH-1:0] at_upd_row,
    output logic [AT_TREE_INDEX_WIDTH-1:0] at_upd_col,
    output logic [AT_TREE_BIT_WIDTH-1:0]   at_upd_bits,

    output logic                           starve_active
);

    localparam int                 c_CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);

    logic [AT_UPD_REQ_WIDTH-1:0]    w_head_raw;
    upd_req_t                       w_head;
    logic                           w_fifo_full;
    logic                           w_fifo_empty;
    logic                           w_upd_push;
    logic                           w_alloc_accept;
    logic                           w_head_hazard;
    logic                           w_pos_hazard;
    logic                           w_upd_issue;
    logic                           w_srch_issue;

    logic                           r_held;
    logic [REQ_ID_WIDTH-1:0]        r_held_id;
    logic [AT_TREE_INDEX_WIDTH-1:0] r_held_pos;
    logic [REQ_SIZE_TYPE_WIDTH-1:0] r_held_size;

    logic                           r_hv1;
    logic                           r_hv2;
    logic [AT_TREE_INDEX_WIDTH-1:0] r_hrow1;
    logic [AT_TREE_INDEX_WIDTH-1:0] r_hrow2;
    logic [c_CNT_W-1:0]             r_starve_cnt;

    at_upd_fifo #(
        .DEPTH (UPD_FIFO_DEPTH),
        .WIDTH (AT_UPD_REQ_WIDTH)
    ) u_upd_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_upd_push),
        .i_push_data (pack_upd_req(upd_row_in, upd_col_in, upd_bits_in)),
        .i_pop       (w_upd_issue),
        .o_head      (w_head_raw),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign w_head          = upd_req_t'(w_head_raw);
    assign starve_active   = (r_starve_cnt == c_STARVE_MAX);

    assign upd_ready_out   = !rst && !w_fifo_full;
    assign w_upd_push      = upd_valid_in && upd_ready_out;
    assign alloc_ready_out = !rst && (!r_held || w_srch_issue);
    assign w_alloc_accept  = alloc_valid_in && alloc_ready_out;

    // Rows written in the last two edges are still inside their RMW window.
    assign w_head_hazard = (r_hv1 && (w_head.row == r_hrow1)) ||
                           (r_hv2 && (w_head.row == r_hrow2));
    assign w_pos_hazard  = (r_hv1 && (r_held_pos == r_hrow1)) ||
                           (r_hv2 && (r_held_pos == r_hrow2));

    assign w_upd_issue  = !w_fifo_empty && !starve_active && !w_head_hazard;
    assign w_srch_issue = r_held && !w_pos_hazard &&
                          !(w_upd_issue && (w_head.row == r_held_pos));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_held         <= 1'b0;
            r_held_id      <= '0;
            r_held_pos     <= '0;
            r_held_size    <= '0;
            r_hv1          <= 1'b0;
            r_hv2          <= 1'b0;
            r_hrow1        <= '0;
            r_hrow2        <= '0;
            r_starve_cnt   <= '0;
            at_alloc_valid <= 1'b0;
            at_alloc_id    <= '0;
            at_alloc_pos   <= '0;
            at_alloc_size  <= '0;
            at_upd_en      <= 1'b0;
            at_upd_row     <= '0;
            at_upd_col     <= '0;
            at_upd_bits    <= '0;
        end else begin
            if (w_alloc_accept) begin
                r_held      <= 1'b1;
                r_held_id   <= alloc_id_in;
                r_held_pos  <= alloc_pos_in;
                r_held_size <= alloc_size_in;
            end else if (w_srch_issue) begin
                r_held      <= 1'b0;
            end

            at_alloc_valid <= w_srch_issue;
            if (w_srch_issue) begin
                at_alloc_id   <= r_held_id;
                at_alloc_pos  <= r_held_pos;
                at_alloc_size <= r_held_size;
            end

            at_upd_en <= w_upd_issue;
            if (w_upd_issue) begin
                at_upd_row  <= w_head.row;
                at_upd_col  <= w_head.col;
                at_upd_bits <= w_head.bits;
            end

            r_hv1   <= w_upd_issue;
            r_hrow1 <= w_head.row;
            r_hv2   <= r_hv1;
            r_hrow2 <= r_hrow1;

            // Saturating count of edges the held search spends blocked.
            if (w_srch_issue) begin
                r_starve_cnt <= '0;
            end else if (r_held && !starve_active) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_at_req_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_at_req_sched
// Brief   : Directed self-checking bench for the and-tree request scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_at_req_sched;
    import at_req_sched_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           alloc_valid_in;
    logic                           alloc_ready_out;
    logic [REQ_ID_WIDTH-1:0]        alloc_id_in;
    logic [AT_TREE_INDEX_WIDTH-1:0] alloc_pos_in;
    logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_size_in;
    logic                           upd_valid_in;
    logic                           upd_ready_out;
    logic [AT_TREE_INDEX_WIDTH-1:0] upd_row_in;
    logic [AT_TREE_INDEX_WIDTH-1:0] upd_col_in;
    logic [AT_TREE_BIT_WIDTH-1:0]   upd_bits_in;
    logic                           at_alloc_valid;
    logic [REQ_ID_WIDTH-1:0]        at_alloc_id;
    logic [AT_TREE_INDEX_WIDTH-1:0] at_alloc_pos;
    logic [REQ_SIZE_TYPE_WIDTH-1:0] at_alloc_size;
    logic                           at_upd_en;
    logic [AT_TREE_INDEX_WIDTH-1:0] at_upd_row;
    logic [AT_TREE_INDEX_WIDTH-1:0] at_upd_col;
    logic [AT_TREE_BIT_WIDTH-1:0]   at_upd_bits;
    logic                           starve_active;

    int n_checks = 0;
    int n_fail   = 0;

    at_req_sched dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid_in  (alloc_valid_in),
        .alloc_ready_out (alloc_ready_out),
        .alloc_id_in     (alloc_id_in),
        .alloc_pos_in    (alloc_pos_in),
        .alloc_size_in   (alloc_size_in),
        .upd_valid_in    (upd_valid_in),
        .upd_ready_out   (upd_ready_out),
        .upd_row_in      (upd_row_in),
        .upd_col_in      (upd_col_in),
        .upd_bits_in     (upd_bits_in),
        .at_alloc_valid  (at_alloc_valid),
        .at_alloc_id     (at_alloc_id),
        .at_alloc_pos    (at_alloc_pos),
        .at_alloc_size   (at_alloc_size),
        .at_upd_en       (at_upd_en),
        .at_upd_row      (at_upd_row),
        .at_upd_col      (at_upd_col),
        .at_upd_bits     (at_upd_bits),
        .starve_active   (starve_active)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input int row, input int col, input int bits);
        upd_valid_in = v;
        upd_row_in   = AT_TREE_INDEX_WIDTH'(row);
        upd_col_in   = AT_TREE_INDEX_WIDTH'(col);
        upd_bits_in  = AT_TREE_BIT_WIDTH'(bits);
    endtask

    task automatic set_alloc(input logic v, input int id, input int pos, input int size);
        alloc_valid_in = v;
        alloc_id_in    = REQ_ID_WIDTH'(id);
        alloc_pos_in   = AT_TREE_INDEX_WIDTH'(pos);
        alloc_size_in  = REQ_SIZE_TYPE_WIDTH'(size);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_upd(1'b0, 0, 0, 0);
        set_alloc(1'b0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset held with both requesters active
        rst = 1'b1;
        set_alloc(1'b1, 5, 3, 2);
        set_upd(1'b1, 4, 1, 4'hA);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t1_rst_alloc_valid", 32'(at_alloc_valid), 0);
            check_eq("t1_rst_upd_en", 32'(at_upd_en), 0);
            check_eq("t1_rst_alloc_ready", 32'(alloc_ready_out), 0);
            check_eq("t1_rst_upd_ready", 32'(upd_ready_out), 0);
        end
        check_eq("t1_rst_starve", 32'(starve_active), 0);
        check_eq("t1_rst_upd_row", 32'(at_upd_row), 0);
        check_eq("t1_rst_alloc_pos", 32'(at_alloc_pos), 0);
        rst = 1'b0;
        #1;
        check_eq("t1_rel_alloc_ready", 32'(alloc_ready_out), 1);
        check_eq("t1_rel_upd_ready", 32'(upd_ready_out), 1);
        step();
        set_alloc(1'b0, 0, 0, 0);
        set_upd(1'b0, 0, 0, 0);
        check_eq("t1_k_alloc_valid", 32'(at_alloc_valid), 0);
        check_eq("t1_k_upd_en", 32'(at_upd_en), 0);
        step();
        check_eq("t1_k1_alloc_valid", 32'(at_alloc_valid), 1);
        check_eq("t1_k1_alloc_pos", 32'(at_alloc_pos), 3);
        check_eq("t1_k1_alloc_id", 32'(at_alloc_id), 5);
        check_eq("t1_k1_alloc_size", 32'(at_alloc_size), 2);
        check_eq("t1_k1_upd_en", 32'(at_upd_en), 1);
        check_eq("t1_k1_upd_row", 32'(at_upd_row), 4);
        check_eq("t1_k1_upd_col", 32'(at_upd_col), 1);
        check_eq("t1_k1_upd_bits", 32'(at_upd_bits), 32'hA);
        step();
        check_eq("t1_k2_alloc_valid", 32'(at_alloc_valid), 0);
        check_eq("t1_k2_upd_en", 32'(at_upd_en), 0);
        check_eq("t1_k2_upd_row_hold", 32'(at_upd_row), 4);

        // Same-row updates are spaced by two bubbles
        do_reset();
        set_upd(1'b1, 5, 3, 1);
        step();
        set_upd(1'b1, 5, 9, 2);
        step();
        set_upd(1'b0, 0, 0, 0);
        check_eq("t2_e1_upd_en", 32'(at_upd_en), 1);
        check_eq("t2_e1_upd_col", 32'(at_upd_col), 3);
        step();
        check_eq("t2_e2_upd_en", 32'(at_upd_en), 0);
        step();
        check_eq("t2_e3_upd_en", 32'(at_upd_en), 0);
        step();
        check_eq("t2_e4_upd_en", 32'(at_upd_en), 1);
        check_eq("t2_e4_upd_row", 32'(at_upd_row), 5);
        check_eq("t2_e4_upd_col", 32'(at_upd_col), 9);

        // Different rows go back-to-back
        do_reset();
        set_upd(1'b1, 5, 1, 3);
        step();
        set_upd(1'b1, 6, 2, 4);
        step();
        set_upd(1'b0, 0, 0, 0);
        check_eq("t2b_f1_upd_row", 32'(at_upd_row), 5);
        check_eq("t2b_f1_upd_en", 32'(at_upd_en), 1);
        step();
        check_eq("t2b_f2_upd_en", 32'(at_upd_en), 1);
        check_eq("t2b_f2_upd_row", 32'(at_upd_row), 6);

        // Search behind an in-flight update on the same row
        do_reset();
        set_upd(1'b1, 12, 0, 0);
        step();
        set_upd(1'b0, 0, 0, 0);
        set_alloc(1'b1, 1, 12, 0);
        step();
        set_alloc(1'b0, 0, 0, 0);
        check_eq("t3_k_upd_en", 32'(at_upd_en), 1);
        check_eq("t3_k_upd_row", 32'(at_upd_row), 12);
        check_eq("t3_k_alloc_valid", 32'(at_alloc_valid), 0);
        check_eq("t3_k_alloc_ready", 32'(alloc_ready_out), 0);
        step();
        check_eq("t3_k1_alloc_valid", 32'(at_alloc_valid), 0);
        check_eq("t3_k1_alloc_ready", 32'(alloc_ready_out), 0);
        step();
        check_eq("t3_k2_alloc_valid", 32'(at_alloc_valid), 0);
        step();
        check_eq("t3_k3_alloc_valid", 32'(at_alloc_valid), 1);
        check_eq("t3_k3_alloc_pos", 32'(at_alloc_pos), 12);

        // Search on a different row is not delayed
        do_reset();
        set_upd(1'b1, 12, 0, 0);
        step();
        set_upd(1'b0, 0, 0, 0);
        set_alloc(1'b1, 2, 13, 1);
        step();
        set_alloc(1'b0, 0, 0, 0);
        check_eq("t3b_j_upd_en", 32'(at_upd_en), 1);
        step();
        check_eq("t3b_j1_alloc_valid", 32'(at_alloc_valid), 1);
        check_eq("t3b_j1_alloc_pos", 32'(at_alloc_pos), 13);
        check_eq("t3b_j1_alloc_id", 32'(at_alloc_id), 2);

        // Same-edge contention on one row: update goes first
        do_reset();
        set_upd(1'b1, 20, 4, 5);
        set_alloc(1'b1, 3, 20, 3);
        step();
        set_upd(1'b0, 0, 0, 0);
        set_alloc(1'b0, 0, 0, 0);
        step();
        check_eq("t3c_m1_upd_en", 32'(at_upd_en), 1);
        check_eq("t3c_m1_alloc_valid", 32'(at_alloc_valid), 0);
        step();
        check_eq("t3c_m2_alloc_valid", 32'(at_alloc_valid), 0);
        step();
        check_eq("t3c_m3_alloc_valid", 32'(at_alloc_valid), 0);
        step();
        check_eq("t3c_m4_alloc_valid", 32'(at_alloc_valid), 1);
        check_eq("t3c_m4_alloc_size", 32'(at_alloc_size), 3);

        // FIFO fill: row 9 pushed each cycle, pops only every third edge
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_upd(1'b1, 9, i, i);
            step();
            case (i)
                1: begin
                    check_eq("t4_p1_upd_en", 32'(at_upd_en), 1);
                    check_eq("t4_p1_upd_col", 32'(at_upd_col), 0);
                end
                2: check_eq("t4_p2_upd_en", 32'(at_upd_en), 0);
                4: begin
                    check_eq("t4_p4_upd_en", 32'(at_upd_en), 1);
                    check_eq("t4_p4_upd_col", 32'(at_upd_col), 1);
                    check_eq("t4_p4_upd_ready", 32'(upd_ready_out), 1);
                end
                5: check_eq("t4_p5_upd_ready", 32'(upd_ready_out), 0);
                6: check_eq("t4_p6_upd_ready", 32'(upd_ready_out), 0);
                default: ;
            endcase
        end
        set_upd(1'b0, 0, 0, 0);
        step();
        check_eq("t4_p7_upd_en", 32'(at_upd_en), 1);
        check_eq("t4_p7_upd_col", 32'(at_upd_col), 2);
        check_eq("t4_p7_upd_ready", 32'(upd_ready_out), 1);
        step();
        step();
        step();
        check_eq("t4_p10_upd_col", 32'(at_upd_col), 3);
        step();
        step();
        step();
        check_eq("t4_p13_upd_col", 32'(at_upd_col), 4);
        step();
        step();
        step();
        check_eq("t4_p16_upd_col", 32'(at_upd_col), 5);
        check_eq("t4_p16_upd_bits", 32'(at_upd_bits), 5);
        step();
        step();
        step();
        check_eq("t4_p19_upd_en", 32'(at_upd_en), 0);

        // Starvation: continuous row 7 updates against a row 7 search
        do_reset();
        set_upd(1'b1, 7, 0, 0);
        set_alloc(1'b1, 6, 7, 1);
        step();
        set_alloc(1'b0, 0, 0, 0);
        for (int s = 1; s <= 11; s++) begin
            set_upd(1'b1, 7, s, 0);
            step();
            case (s)
                1: check_eq("t5_s1_upd_en", 32'(at_upd_en), 1);
                4: check_eq("t5_s4_upd_en", 32'(at_upd_en), 1);
                7: begin
                    check_eq("t5_s7_upd_en", 32'(at_upd_en), 1);
                    check_eq("t5_s7_starve", 32'(starve_active), 0);
                end
                8: begin
                    check_eq("t5_s8_starve", 32'(starve_active), 1);
                    check_eq("t5_s8_alloc_ready", 32'(alloc_ready_out), 0);
                end
                9: begin
                    check_eq("t5_s9_upd_en", 32'(at_upd_en), 0);
                    check_eq("t5_s9_alloc_valid", 32'(at_alloc_valid), 0);
                    check_eq("t5_s9_starve", 32'(starve_active), 1);
                end
                10: begin
                    check_eq("t5_s10_upd_en", 32'(at_upd_en), 0);
                    check_eq("t5_s10_alloc_valid", 32'(at_alloc_valid), 1);
                    check_eq("t5_s10_alloc_pos", 32'(at_alloc_pos), 7);
                    check_eq("t5_s10_starve", 32'(starve_active), 0);
                end
                11: check_eq("t5_s11_upd_en", 32'(at_upd_en), 1);
                default: ;
            endcase
        end
        set_upd(1'b0, 0, 0, 0);

        // Mid-operation reset drops buffered and held work
        do_reset();
        for (int t = 0; t < 4; t++) begin
            set_upd(1'b1, 10, t, 0);
            if (t == 2) set_alloc(1'b1, 7, 10, 0);
            else        set_alloc(1'b0, 0, 0, 0);
            step();
        end
        set_upd(1'b0, 0, 0, 0);
        set_alloc(1'b0, 0, 0, 0);
        check_eq("t6_pre_upd_ready", 32'(upd_ready_out), 1);
        check_eq("t6_pre_alloc_ready", 32'(alloc_ready_out), 0);
        check_eq("t6_pre_upd_row", 32'(at_upd_row), 10);
        rst = 1'b1;
        step();
        check_eq("t6_rst_upd_row", 32'(at_upd_row), 0);
        check_eq("t6_rst_upd_en", 32'(at_upd_en), 0);
        rst = 1'b0;
        #1;
        check_eq("t6_rel_upd_ready", 32'(upd_ready_out), 1);
        check_eq("t6_rel_alloc_ready", 32'(alloc_ready_out), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t6_post_upd_en", 32'(at_upd_en), 0);
            check_eq("t6_post_alloc_valid", 32'(at_alloc_valid), 0);
        end
        check_eq("t6_post_starve", 32'(starve_active), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
